// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package riscv_mem_pkg;

  localparam logic OWNER_I     = 1'b0;
  localparam logic OWNER_D     = 1'b1;
  localparam int   DATA_W_DFLT = 32;
  localparam int   ADDR_W_DFLT = 32;
  localparam int   BE_W        = DATA_W_DFLT / 8;

  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_I,
    GNT_D
  } gnt_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side I/D ports and memory-side port of the arbiter, bundled as one interface.
interface mem_port_arbiter_if
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = DATA_W_DFLT
);
  logic                  i_req;
  logic [ADDR_W-1:0]     i_addr;
  logic                  i_gnt;
  logic                  i_rvalid;
  logic [DATA_W-1:0]     i_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_be;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;

  logic                  m_en;
  logic                  m_we;
  logic [ADDR_W-3:0]     m_addr;
  logic [DATA_W-1:0]     m_wdata;
  logic [DATA_W/8-1:0]   m_be;
  logic [DATA_W-1:0]     m_rdata;

  logic                  stall_if;
  logic                  stall_mem;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, m_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_en, m_we, m_addr, m_wdata, m_be, stall_if, stall_mem
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_en, m_we, m_addr, m_wdata, m_be, stall_if, stall_mem
  );

endinterface

// File: rtl/resp_tag_pipe.sv
// Fixed-depth shift register of read tags; the tail says who owns the data on m_rdata.
module resp_tag_pipe
  import riscv_mem_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_i,
  output logic valid_o,
  output logic owner_o
);

  tag_t pipe_q [MEM_LAT];
  tag_t pipe_d [MEM_LAT];

  always_comb begin
    pipe_d[0] = tag_i;
    for (int i = 1; i < MEM_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MEM_LAT; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign valid_o = pipe_q[MEM_LAT-1].valid;
  assign owner_o = pipe_q[MEM_LAT-1].owner;

endmodule

// File: rtl/mem_port_arbiter.sv
// D-priority arbiter for a single-ported memory shared by instruction fetch and load/store,
// with a starvation guard for fetch and tag-routed fixed-latency read responses.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DFLT,
  parameter int DATA_W     = DATA_W_DFLT,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  localparam int              CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_TOP = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_q, starve_d;
  gnt_e             gnt;
  tag_t             tag_in;
  logic             tail_valid;
  logic             tail_owner;
  logic             unused_addr_lsbs;

  // Byte offset within a word is irrelevant to a word-wide memory.
  assign unused_addr_lsbs = ^{bus.i_addr[1:0], bus.d_addr[1:0]};

  // Grants are forced off while reset is held so every output reads 0.
  always_comb begin
    gnt = GNT_NONE;
    if (!rst) begin
      if (bus.d_req && !(bus.i_req && starve_q == STARVE_TOP)) begin
        gnt = GNT_D;
      end else if (bus.i_req) begin
        gnt = GNT_I;
      end
    end
  end

  always_comb begin
    starve_d = '0;
    if (bus.i_req && gnt != GNT_I) begin
      starve_d = (starve_q == STARVE_TOP) ? starve_q : starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  always_comb begin
    bus.i_gnt   = (gnt == GNT_I);
    bus.d_gnt   = (gnt == GNT_D);
    bus.m_en    = (gnt != GNT_NONE);
    bus.m_we    = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.m_be    = '0;
    unique case (gnt)
      GNT_I: begin
        bus.m_addr = bus.i_addr[ADDR_W-1:2];
        bus.m_be   = '1;
      end
      GNT_D: begin
        bus.m_addr  = bus.d_addr[ADDR_W-1:2];
        bus.m_we    = bus.d_we;
        bus.m_wdata = bus.d_wdata;
        bus.m_be    = bus.d_be;
      end
      default: ;
    endcase
  end

  assign bus.stall_if  = bus.i_req & ~bus.i_gnt & ~rst;
  assign bus.stall_mem = bus.d_req & ~bus.d_gnt & ~rst;

  always_comb begin
    tag_in       = '0;
    tag_in.valid = (gnt == GNT_I) || (gnt == GNT_D && !bus.d_we);
    tag_in.owner = (gnt == GNT_D) ? OWNER_D : OWNER_I;
  end

  resp_tag_pipe #(
    .MEM_LAT (MEM_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_i   (tag_in),
    .valid_o (tail_valid),
    .owner_o (tail_owner)
  );

  assign bus.i_rvalid = tail_valid && (tail_owner == OWNER_I);
  assign bus.d_rvalid = tail_valid && (tail_owner == OWNER_D);
  assign bus.i_rdata  = rst ? '0 : bus.m_rdata;
  assign bus.d_rdata  = rst ? '0 : bus.m_rdata;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the pipelined RISC-V core's instruction-fetch port (I) and load/store port (D).
- Sits between the core's IF/MEM stages and the memory array; the arbiter owns all memory enables.
- Arbitration is D-priority with a starvation guard for I.
- Read responses are routed back by a tag pipeline and arrive at a fixed latency.

Parameters:
- ADDR_W, 32, byte-address width of both ports.
- DATA_W, 32, data width; byte enables are DATA_W/8 wide.
- MEM_LAT, 1, memory read latency in cycles (1..4); m_rdata is valid MEM_LAT cycles after m_en.
- STARVE_MAX, 3, maximum consecutive cycles I may be denied before it wins.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  instruction read request.
- i_addr  in  ADDR_W  instruction byte address.
- i_gnt  out  1  I request accepted this cycle.
- i_rvalid  out  1  I read data valid.
- i_rdata  out  DATA_W  I read data.
- d_req  in  1  data request.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  write data.
- d_be  in  DATA_W/8  byte enables.
- d_gnt  out  1  D request accepted this cycle.
- d_rvalid  out  1  D read data valid.
- d_rdata  out  DATA_W  D read data.
- m_en  out  1  memory access strobe.
- m_we  out  1  memory write.
- m_addr  out  ADDR_W-2  word address.
- m_wdata  out  DATA_W  memory write data.
- m_be  out  DATA_W/8  memory byte enables.
- m_rdata  in  DATA_W  memory read data.
- stall_if  out  1  i_req & ~i_gnt, to pipeline hazard logic.
- stall_mem  out  1  d_req & ~d_gnt.

Behaviour:
- Reset (async, any cycle): all outputs 0, tag pipeline cleared, starve_cnt = 0. In-flight reads are dropped and no rvalid is issued for them after reset releases.
- At most one grant per cycle. Grants are combinational from req and state; m_en = i_gnt | d_gnt in the same cycle.
- Requester rule: hold req and its address/data stable until gnt. The arbiter does not check this; the bench does.
- Priority:
  - Only one port requesting: that port is granted.
  - Both requesting: D is granted unless starve_cnt == STARVE_MAX, in which case I is granted.
- starve_cnt:
  - Increments when i_req & ~i_gnt.
  - Clears to 0 on i_gnt or ~i_req.
  - Saturates at STARVE_MAX.
- Mux:
  - m_addr = granted_addr[ADDR_W-1:2]; the two LSBs are ignored.
  - I grant drives m_we = 0 and m_be = all ones.
  - D grant drives m_we, m_wdata and m_be from d_*.
  - With no grant, m_we, m_wdata and m_be are 0.
- Response tags:
  - Each read grant pushes {valid=1, owner} into a MEM_LAT-deep shift register. Writes and idle cycles push valid=0.
  - At the tail: owner I asserts i_rvalid; owner D asserts d_rvalid.
  - i_rdata and d_rdata are both driven from m_rdata; each is qualified only by its own rvalid.
  - Latency is exactly MEM_LAT cycles from grant edge to rvalid.
- Writes: complete at grant; no rvalid.
- Back-to-back reads are fully pipelined: one response per cycle, in grant order.
- A new grant in the cycle a response retires is legal.

Decomposition:
- Package riscv_mem_pkg:
  - OWNER_I / OWNER_D constants.
  - Derived BE_W = DATA_W/8.
  - Tag struct {valid, owner}.
- One sub-module, resp_tag_pipe: parameterised MEM_LAT shift register of tags, async reset. It outputs tail valid and owner.

Test Plan:
- I-only read, MEM_LAT=1, i_addr=0x0000_0010, memory word 4 = 0xDEAD_BEEF -> i_gnt the same cycle, m_addr=4, i_rvalid=1 with i_rdata=0xDEAD_BEEF exactly 1 cycle later.
- I and D both request continuously (D reads), STARVE_MAX=3 -> D granted 3 cycles, I granted on the 4th, pattern repeats; stall_if high exactly 3 of every 4 cycles.
- D write d_addr=0x20, d_be=4'b0011, d_wdata=0x1234_5678, then D read 0x20 over memory preloaded 0xFFFF_FFFF -> m_we=1 for one cycle, no d_rvalid for the write, read returns 0xFFFF_5678.
- MEM_LAT=3, alternating I/D reads on consecutive cycles -> rvalids alternate I, D, I, D starting 3 cycles after the first grant; no data routed to the wrong port.
- rst asserted asynchronously between clock edges with 2 reads in flight (MEM_LAT=3) -> all outputs 0 immediately; no rvalid after release; starve_cnt restarts at 0.
- Neither port requesting -> m_en=0, m_we=0, gnts=0, no rvalid after MEM_LAT.
